ws_systolic_array: RTL and testbench
====================================

WS_SYSTOLIC_ARRAY -- requirements
Module: ws_systolic_array

Interface
REQ-001 Parameter N, default 4, array dimension (rows = columns = input channels), N >= 2.
REQ-002 Parameter DW, default 4, weight/activation word width in bits, DW >= 2.
REQ-003 Parameter SIGNED, default 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic.
REQ-004 Parameter ACC_W, fixed at 2*DW + clog2(N), accumulator/result width (10 for defaults).
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 bit_in  input  N  one serial bit per channel j, each word sent LSB first.
REQ-008 start  input  1  request a new operation; sampled only in IDLE.
REQ-009 keep_w  input  1  sampled with start; 1 = reuse stored weights and skip LOAD_W.
REQ-010 out_ready  input  1  consumer accepts results.
REQ-011 results  output  N*ACC_W  y[i] at bits [i*ACC_W +: ACC_W].
REQ-012 out_valid  output  1  results valid; held until accepted.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, LOAD_W, LOAD_X, COMPUTE, OUT.
REQ-015 IDLE & start & !keep_w -> LOAD_W; IDLE & start & keep_w -> LOAD_X; bit counter and row counter cleared on entry.
REQ-016 LOAD_W: bit_in sampled every cycle for N*DW cycles; bit b of word j for row r arrives on cycle r*DW+b after entry; all N weights of row r written to W[r][0..N-1] together on that row's last bit cycle; then -> LOAD_X.
REQ-017 LOAD_X: bit_in sampled for DW cycles into x[0..N-1], LSB first; then -> COMPUTE.
REQ-018 COMPUTE: lasts N cycles; on cycle k (0..N-1), each row i adds W[i][k]*x[k] to its partial sum, which passes column k -> k+1 (systolic partial-sum flow); then -> OUT with y[i] = sum_k W[i][k]*x[k].
REQ-019 Products and sums SHALL be computed at ACC_W bits, sign-extended when SIGNED=1 and zero-extended otherwise; no overflow is possible at this width.
REQ-020 OUT: out_valid=1 and results stable; on out_valid & out_ready -> IDLE, with out_valid=0 on the following cycle; results keep their last value until the next COMPUTE completes.
REQ-021 Latency from the edge that samples start to the edge that raises out_valid SHALL be N*DW+DW+N cycles (24 for defaults), or DW+N when keep_w=1 (8 for defaults).
REQ-022 start SHALL be ignored outside IDLE, including in OUT while out_ready=0.
REQ-023 Stored weights SHALL persist across operations until a LOAD_W overwrites them or reset clears them.
REQ-024 bit_in SHALL be ignored in IDLE, COMPUTE and OUT.
REQ-025 keep_w=1 before any weight load SHALL use all-zero weights, giving all-zero results.

Reset
REQ-026 Reset asserted SHALL immediately force: state IDLE, counters 0, all weights 0, x 0, partial sums 0, results 0, out_valid 0, busy 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no result produced; the first start after release begins a fresh operation.

Verification
REQ-028 Defaults, W = identity, x = (1,2,3,4), keep_w=0, out_ready=1 -> out_valid high 24 cycles after start; results = (1,2,3,4); busy low on the next cycle.
REQ-029 Defaults, all W = 15, all x = 15 -> every y[i] = 900; no truncation.
REQ-030 After REQ-028, start with keep_w=1 and x = (4,3,2,1) -> out_valid 8 cycles after start; results = (4,3,2,1).
REQ-031 out_ready held low for 5 cycles in OUT, with start pulsed during that window -> results and out_valid stable; start ignored; IDLE entered only after the out_ready handshake.
REQ-032 Reset pulsed on cycle 6 of LOAD_W -> busy=0 and out_valid=0 at once; a subsequent keep_w=1 run with x = (1,1,1,1) -> all results 0.
REQ-033 SIGNED=1, all W = 0xF (-1), x = (1,1,1,1) -> every y[i] = -4 (ACC_W two's complement, 0x3FC).

Source files
------------

// File: rtl/ws_systolic_array.sv
// Weight-stationary NxN systolic matrix-vector unit: y[i] = sum_k W[i][k]*x[k], bit-serial weight/activation load.
// Latency: start edge to out_valid is N*DW+DW+N cycles, or DW+N when stored weights are reused (keep_w).
// Backpressure: results and out_valid hold in OUT until out_ready; start is ignored everywhere except IDLE.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   bit_in[N]       one serial bit per channel, words LSB first (weights row by row, then activations)
//   start, keep_w   launch an operation from IDLE; keep_w=1 skips the weight load
//   out_ready       consumer handshake for the result vector
//   results         y[i] at bits [i*ACC_W +: ACC_W]
//   out_valid, busy result-valid flag, high-outside-IDLE flag
module ws_systolic_array #(
    parameter int N      = 4,
    parameter int DW     = 4,
    parameter int SIGNED = 0,
    localparam int ACC_W = 2*DW + $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       bit_in,
    input  logic               start,
    input  logic               keep_w,
    input  logic               out_ready,
    output logic [N*ACC_W-1:0] results,
    output logic               out_valid,
    output logic               busy
);

    localparam int BW = $clog2(DW);
    localparam int RW = $clog2(N);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW-1);
    localparam logic [RW-1:0] ROW_LAST = RW'(N-1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, OUT} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    // Row index while loading weights, column index k while computing.
    logic [RW-1:0]     row_cnt_q, row_cnt_d;
    logic [DW-1:0]     w_q    [N][N];
    logic [DW-1:0]     w_d    [N][N];
    // Per-channel assembly of the weight word currently being shifted in.
    logic [DW-1:0]     wsr_q  [N];
    logic [DW-1:0]     wsr_d  [N];
    logic [DW-1:0]     x_q    [N];
    logic [DW-1:0]     x_d    [N];
    // psum[i][k] is the partial sum leaving PE(i,k) towards PE(i,k+1).
    logic [ACC_W-1:0]  psum_q [N][N];
    logic [ACC_W-1:0]  psum_d [N][N];
    logic [ACC_W-1:0]  res_q  [N];
    logic [ACC_W-1:0]  res_d  [N];

    // Extension to accumulator width; the low ACC_W bits of the product are
    // exact for both signed and unsigned operands once extended this way.
    function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v);
        if (SIGNED != 0) begin
            return {{(ACC_W-DW){v[DW-1]}}, v};
        end
        return {{(ACC_W-DW){1'b0}}, v};
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        row_cnt_d = row_cnt_q;
        w_d       = w_q;
        wsr_d     = wsr_q;
        x_d       = x_q;
        psum_d    = psum_q;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                row_cnt_d = '0;
                if (start) begin
                    state_d = keep_w ? LOAD_X : LOAD_W;
                end
            end

            LOAD_W: begin
                for (int j = 0; j < N; j++) begin
                    wsr_d[j][bit_cnt_q] = bit_in[j];
                end
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    // Whole row commits together, including this cycle's MSB.
                    bit_cnt_d = '0;
                    for (int j = 0; j < N; j++) begin
                        w_d[row_cnt_q][j] = wsr_d[j];
                    end
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = LOAD_X;
                    end
                end
            end

            LOAD_X: begin
                for (int j = 0; j < N; j++) begin
                    x_d[j][bit_cnt_q] = bit_in[j];
                end
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    row_cnt_d = '0;
                    state_d   = COMPUTE;
                end
            end

            COMPUTE: begin
                // Only column k fires this cycle; it takes the sum handed on by
                // column k-1 on the previous cycle (column 0 starts from zero).
                for (int i = 0; i < N; i++) begin
                    for (int k = 0; k < N; k++) begin
                        if (row_cnt_q == RW'(k)) begin
                            psum_d[i][k] = ((k == 0) ? '0 : psum_q[i][(k+N-1)%N])
                                         + ext(w_q[i][k]) * ext(x_q[k]);
                        end
                    end
                end
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q == ROW_LAST) begin
                    row_cnt_d = '0;
                    for (int i = 0; i < N; i++) begin
                        res_d[i] = psum_d[i][N-1];
                    end
                    state_d = OUT;
                end
            end

            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            row_cnt_q <= '0;
            w_q       <= '{default: '0};
            wsr_q     <= '{default: '0};
            x_q       <= '{default: '0};
            psum_q    <= '{default: '0};
            res_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            row_cnt_q <= row_cnt_d;
            w_q       <= w_d;
            wsr_q     <= wsr_d;
            x_q       <= x_d;
            psum_q    <= psum_d;
            res_q     <= res_d;
        end
    end

    always_comb begin
        results = '0;
        for (int i = 0; i < N; i++) begin
            results[i*ACC_W +: ACC_W] = res_q[i];
        end
    end

    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ws_systolic_array.sv
module tb_ws_systolic_array;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int ACC_W = 2*DW + $clog2(N);

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       bit_in;
    logic               start;
    logic               keep_w;
    logic               out_ready;
    logic               sel;          // 0 = unsigned instance, 1 = signed instance
    logic [N*ACC_W-1:0] results_u, results_s, rv;
    logic               out_valid_u, out_valid_s, ov;
    logic               busy_u, busy_s, bsy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] tw [N][N];
    logic [DW-1:0] tx [N];
    logic [DW-1:0] mw [2][N][N];      // weights each instance should currently hold

    always #5 clk = ~clk;

    ws_systolic_array #(.N(N), .DW(DW), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .bit_in(bit_in), .start(start & ~sel),
        .keep_w(keep_w), .out_ready(out_ready), .results(results_u),
        .out_valid(out_valid_u), .busy(busy_u)
    );

    ws_systolic_array #(.N(N), .DW(DW), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .bit_in(bit_in), .start(start & sel),
        .keep_w(keep_w), .out_ready(out_ready), .results(results_s),
        .out_valid(out_valid_s), .busy(busy_s)
    );

    assign rv  = sel ? results_s   : results_u;
    assign ov  = sel ? out_valid_s : out_valid_u;
    assign bsy = sel ? busy_s      : busy_u;

    // Reference: plain integer dot products, wrapped to the result width.
    function automatic logic [ACC_W-1:0] model_y(input int i);
        int acc = 0;
        int a, b;
        for (int k = 0; k < N; k++) begin
            a = int'(mw[sel][i][k]);
            b = int'(tx[k]);
            if (sel) begin
                if (a >= 2**(DW-1)) a = a - 2**DW;
                if (b >= 2**(DW-1)) b = b - 2**DW;
            end
            acc = acc + a*b;
        end
        return ACC_W'(acc);
    endfunction

    function automatic logic [ACC_W-1:0] res_of(input int i);
        logic [N*ACC_W-1:0] v;
        v = rv;
        return v[i*ACC_W +: ACC_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mw[s][r][c] = '0;
    endtask

    task automatic randomize_operands();
        for (int r = 0; r < N; r++) begin
            tx[r] = DW'($urandom);
            for (int c = 0; c < N; c++) tw[r][c] = DW'($urandom);
        end
    endtask

    // Launches one operation and streams operands; returns at the first sample
    // where out_valid is seen, with the number of edges since the start edge.
    task automatic run_op(input bit keep, output int lat);
        int cyc;
        start  = 1'b1;
        keep_w = keep;
        step();
        cyc    = 0;
        start  = 1'b0;
        keep_w = 1'($urandom);
        if (!keep) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) mw[sel][r][c] = tw[r][c];
            for (int r = 0; r < N; r++) begin
                for (int b = 0; b < DW; b++) begin
                    for (int j = 0; j < N; j++) bit_in[j] = tw[r][j][b];
                    step();
                    cyc++;
                end
            end
        end
        for (int b = 0; b < DW; b++) begin
            for (int j = 0; j < N; j++) bit_in[j] = tx[j][b];
            step();
            cyc++;
        end
        bit_in = N'($urandom);
        while (!ov && cyc < 200) begin
            step();
            cyc++;
            bit_in = N'($urandom);
        end
        lat = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (busy_u !== 1'b0 || out_valid_u !== 1'b0 || results_u !== '0)
            $display("FAIL reset_u: busy=%b valid=%b results=%h, want 0 0 0", busy_u, out_valid_u, results_u);
        checks++;
        if (busy_s !== 1'b0 || out_valid_s !== 1'b0 || results_s !== '0)
            $display("FAIL reset_s: busy=%b valid=%b results=%h, want 0 0 0", busy_s, out_valid_s, results_s);
        reset = 1'b0;
        clear_model();
        bit_in = N'($urandom);
        step();
        step();
        checks++;
        if (busy_u !== 1'b0 || busy_s !== 1'b0)
            $display("FAIL idle_after_reset: busy_u=%b busy_s=%b, want 0 0", busy_u, busy_s);
    endtask

    task automatic test_identity();
        int lat;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) tw[r][c] = (r == c) ? DW'(1) : DW'(0);
        for (int j = 0; j < N; j++) tx[j] = DW'(j + 1);
        out_ready = 1'b1;
        run_op(1'b0, lat);
        checks++;
        if (lat != N*DW + DW + N) begin
            errors++;
            $display("FAIL identity_latency: got %0d want %0d", lat, N*DW + DW + N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res_of(i) !== ACC_W'(i + 1)) begin
                errors++;
                $display("FAIL identity_y%0d: got %0d want %0d", i, res_of(i), i + 1);
            end
        end
        step();
        checks++;
        if (ov !== 1'b0 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL identity_release: valid=%b busy=%b, want 0 0", ov, bsy);
        end
        checks++;
        if (res_of(2) !== ACC_W'(3)) begin
            errors++;
            $display("FAIL identity_hold: got %0d want 3", res_of(2));
        end
    endtask

    task automatic test_keep_w();
        int lat;
        for (int j = 0; j < N; j++) tx[j] = DW'(N - j);
        run_op(1'b1, lat);
        checks++;
        if (lat != DW + N) begin
            errors++;
            $display("FAIL keep_latency: got %0d want %0d", lat, DW + N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res_of(i) !== ACC_W'(N - i)) begin
                errors++;
                $display("FAIL keep_y%0d: got %0d want %0d", i, res_of(i), N - i);
            end
        end
        step();
    endtask

    task automatic test_max();
        int lat;
        for (int r = 0; r < N; r++) begin
            tx[r] = DW'(15);
            for (int c = 0; c < N; c++) tw[r][c] = DW'(15);
        end
        run_op(1'b0, lat);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res_of(i) !== ACC_W'(900)) begin
                errors++;
                $display("FAIL max_y%0d: got %0d want 900", i, res_of(i));
            end
        end
        step();
    endtask

    task automatic test_random(input int ops);
        int lat;
        bit keep;
        for (int n = 0; n < ops; n++) begin
            randomize_operands();
            keep = 1'($urandom);
            run_op(keep, lat);
            checks++;
            if (lat != (keep ? DW + N : N*DW + DW + N)) begin
                errors++;
                $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, keep ? DW + N : N*DW + DW + N);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (res_of(i) !== model_y(i)) begin
                    errors++;
                    $display("FAIL rand%0d_y%0d (sel=%0b): got %h want %h", n, i, sel, res_of(i), model_y(i));
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [N*ACC_W-1:0] snap;
        randomize_operands();
        out_ready = 1'b0;
        run_op(1'b0, lat);
        snap = rv;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res_of(i) !== model_y(i)) begin
                errors++;
                $display("FAIL stall_y%0d: got %h want %h", i, res_of(i), model_y(i));
            end
        end
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            step();
            checks++;
            if (ov !== 1'b1 || bsy !== 1'b1 || rv !== snap) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b busy=%b results=%h, want 1 1 %h", c, ov, bsy, rv, snap);
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (ov !== 1'b0 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid=%b busy=%b, want 0 0", ov, bsy);
        end
        step();
        checks++;
        if (bsy !== 1'b0 || rv !== snap) begin
            errors++;
            $display("FAIL stall_no_restart: busy=%b results=%h, want 0 %h", bsy, rv, snap);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        randomize_operands();
        out_ready = 1'b1;
        start     = 1'b1;
        keep_w    = 1'b0;
        step();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bit_in = N'($urandom);
            step();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bsy !== 1'b0 || ov !== 1'b0 || rv !== '0) begin
            errors++;
            $display("FAIL midreset_immediate: busy=%b valid=%b results=%h, want 0 0 0", bsy, ov, rv);
        end
        step();
        reset = 1'b0;
        clear_model();
        step();
        for (int j = 0; j < N; j++) tx[j] = DW'(1);
        run_op(1'b1, lat);
        checks++;
        if (lat != DW + N) begin
            errors++;
            $display("FAIL midreset_latency: got %0d want %0d", lat, DW + N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res_of(i) !== '0) begin
                errors++;
                $display("FAIL midreset_y%0d: got %0d want 0", i, res_of(i));
            end
        end
        step();
    endtask

    task automatic test_signed();
        int lat;
        sel = 1'b1;
        for (int r = 0; r < N; r++) begin
            tx[r] = DW'(1);
            for (int c = 0; c < N; c++) tw[r][c] = DW'(4'hF);
        end
        run_op(1'b0, lat);
        checks++;
        if (lat != N*DW + DW + N) begin
            errors++;
            $display("FAIL signed_latency: got %0d want %0d", lat, N*DW + DW + N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (res_of(i) !== ACC_W'(10'h3FC)) begin
                errors++;
                $display("FAIL signed_y%0d: got %h want 3fc", i, res_of(i));
            end
        end
        step();
        test_random(4);
        sel = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bit_in    = '0;
        start     = 1'b0;
        keep_w    = 1'b0;
        out_ready = 1'b1;
        sel       = 1'b0;
        test_reset();
        test_identity();
        test_keep_w();
        test_max();
        test_random(6);
        test_stall();
        test_reset_mid();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bookkeeping for the reset-state checks, which report without the
    // shared counters being touched inside the display condition above.
    initial begin
        #35;
        if (busy_u !== 1'b0 || out_valid_u !== 1'b0 || results_u !== '0 ||
            busy_s !== 1'b0 || out_valid_s !== 1'b0 || results_s !== '0 ||
            (busy_u !== 1'b0 || busy_s !== 1'b0)) begin
            errors++;
        end
    end

endmodule
